// File: rtl/branch_predictor.sv
// Direct-mapped 2-bit saturating-counter branch predictor.
// Combinational lookup for decode, training from resolved EX branches, misprediction statistics.
module branch_predictor #(
    parameter int INDEX_BITS = 4,
    parameter int PC_WIDTH   = 64,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [PC_WIDTH-1:0]  id_pc,
    input  logic                 id_is_branch,
    input  logic                 id_is_jump,
    input  logic                 ex_update_en,
    input  logic [PC_WIDTH-1:0]  ex_pc,
    input  logic                 ex_taken,
    input  logic                 ex_predicted,
    output logic                 prediction,
    output logic                 mispredict,
    output logic [CNT_WIDTH-1:0] branch_count,
    output logic [CNT_WIDTH-1:0] mispredict_count
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam logic [1:0] CTR_STRONG_NT = 2'b00;
    localparam logic [1:0] CTR_WEAK_NT   = 2'b01;
    localparam logic [1:0] CTR_STRONG_T  = 2'b11;

    logic [1:0]            table_q [ENTRIES];
    logic [INDEX_BITS-1:0] id_idx;
    logic [INDEX_BITS-1:0] ex_idx;
    logic [1:0]            ex_ctr;
    logic [1:0]            ex_ctr_d;
    logic                  ex_wrong;

    logic [CNT_WIDTH-1:0]  branch_count_q;
    logic [CNT_WIDTH-1:0]  branch_count_d;
    logic [CNT_WIDTH-1:0]  mispredict_count_q;
    logic [CNT_WIDTH-1:0]  mispredict_count_d;
    logic                  mispredict_q;
    logic                  mispredict_d;

    // PC bits outside the index field are deliberately ignored.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{id_pc[PC_WIDTH-1:INDEX_BITS+2], id_pc[1:0],
                              ex_pc[PC_WIDTH-1:INDEX_BITS+2], ex_pc[1:0]};

    assign id_idx = id_pc[INDEX_BITS+1:2];
    assign ex_idx = ex_pc[INDEX_BITS+1:2];
    assign ex_ctr = table_q[ex_idx];

    // Lookup reads the registered table, so a same-cycle update is seen next cycle.
    always_comb begin
        prediction = 1'b0;
        if (id_is_jump) begin
            prediction = 1'b1;
        end else if (id_is_branch) begin
            prediction = table_q[id_idx][1];
        end
    end

    always_comb begin
        ex_ctr_d = ex_ctr;
        if (ex_taken) begin
            if (ex_ctr != CTR_STRONG_T) begin
                ex_ctr_d = ex_ctr + 2'b01;
            end
        end else begin
            if (ex_ctr != CTR_STRONG_NT) begin
                ex_ctr_d = ex_ctr - 2'b01;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    table_q[gi] <= CTR_WEAK_NT;
                end else if (ex_update_en && (ex_idx == INDEX_BITS'(gi))) begin
                    table_q[gi] <= ex_ctr_d;
                end
            end
        end
    endgenerate

    assign ex_wrong = ex_taken ^ ex_predicted;

    always_comb begin
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;
        mispredict_d       = ex_update_en & ex_wrong;
        if (ex_update_en) begin
            if (branch_count_q != {CNT_WIDTH{1'b1}}) begin
                branch_count_d = branch_count_q + 1'b1;
            end
            if (ex_wrong && (mispredict_count_q != {CNT_WIDTH{1'b1}})) begin
                mispredict_count_d = mispredict_count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
            mispredict_q       <= 1'b0;
        end else begin
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
            mispredict_q       <= mispredict_d;
        end
    end

    assign mispredict       = mispredict_q;
    assign branch_count     = branch_count_q;
    assign mispredict_count = mispredict_count_q;

endmodule
